// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: pipeline hazard inputs toward the controller, and the
// stall/flush/status outputs back to the pipeline registers.
interface hazard_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rs1_D;
    logic [4:0]       rs2_D;
    logic [4:0]       rd_E;
    logic             RegWrite_E;
    logic             MemRead_E;
    logic             PCSrc_E;
    logic             dmem_req_M;
    logic             dmem_ready_M;
    logic             Stall_F;
    logic             Stall_D;
    logic             Stall_E;
    logic             Stall_M;
    logic             Flush_D;
    logic             Flush_E;
    logic             Flush_W;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_D, rs2_D, rd_E, RegWrite_E, MemRead_E, PCSrc_E, dmem_req_M, dmem_ready_M,
        input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
        input  mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_D, rs2_D, rd_E, RegWrite_E, MemRead_E, PCSrc_E, dmem_req_M, dmem_ready_M,
        output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
        output mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush control for load-use, taken-branch and data-memory-wait hazards,
// with a wait watchdog and saturating stall/flush event counters.
module hazard_stall_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input logic               clk,
    input logic               rst_n,
    hazard_stall_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2} state_t;

    localparam logic [15:0] WCNT_MAX = 16'(TIMEOUT);

    state_t           state_q;
    logic [15:0]      wcnt_q;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu, mw, mw_act;
    logic stall_fd, stall_em, flush_d, flush_e, flush_w, br_take;

    assign lu = hz.MemRead_E & hz.RegWrite_E & (hz.rd_E != 5'd0) &
                ((hz.rd_E == hz.rs1_D) | (hz.rd_E == hz.rs2_D));
    assign mw = hz.dmem_req_M & ~hz.dmem_ready_M;
    // ERR lets the timed-out access retire, so the wait is not honoured there.
    assign mw_act = mw & (state_q != ERR);

    always_comb begin
        stall_fd = 1'b0;
        stall_em = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_w  = 1'b0;
        br_take  = 1'b0;
        if (rst_n) begin
            if (mw_act) begin
                stall_fd = 1'b1;
                stall_em = 1'b1;
                flush_w  = 1'b1;
            end else if (hz.PCSrc_E) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                br_take = 1'b1;
            end else if (lu) begin
                stall_fd = 1'b1;
                flush_e  = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_fd && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (br_take && flush_cnt_q != '1)  flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wcnt_q      <= 16'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            case (state_q)
                RUN: begin
                    if (mw) begin
                        state_q <= MEM_WAIT;
                        wcnt_q  <= 16'd1;
                    end
                end
                MEM_WAIT: begin
                    if (hz.dmem_ready_M) begin
                        state_q <= RUN;
                        wcnt_q  <= 16'd0;
                    end else if (wcnt_q == WCNT_MAX) begin
                        state_q   <= ERR;
                        timeout_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + 16'd1;
                    end
                end
                ERR: begin
                    state_q <= RUN;
                    wcnt_q  <= 16'd0;
                end
                default: begin
                    state_q <= RUN;
                    wcnt_q  <= 16'd0;
                end
            endcase
        end
    end

    assign hz.Stall_F     = stall_fd;
    assign hz.Stall_D     = stall_fd;
    assign hz.Stall_E     = stall_em;
    assign hz.Stall_M     = stall_em;
    assign hz.Flush_D     = flush_d;
    assign hz.Flush_E     = flush_e;
    assign hz.Flush_W     = flush_w;
    assign hz.mem_timeout = timeout_q;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
endmodule
